// File: rtl/demux_frame_serializer.sv
// Frame serializer feeding a 1-to-4 demux: header word picks the channel, payload words go out one bit per clock.
// Optional frame parity bit after the last payload word is enabled by defining DEMUX_PARITY_EN.
module demux_frame_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              d,
  output logic [1:0]        s,
  output logic              d_vld,
  output logic              par_vld
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
`ifdef DEMUX_PARITY_EN
    , ST_PAR = 2'd3
`endif
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              last_flag_reg;
  logic              d_reg;
  logic [1:0]        s_reg;
  logic              d_vld_reg;
  logic              ready_next;
  logic              transfer;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  // Shift the already-emitted bit out so first_bit() always yields the next one.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  always_comb begin
    ready_next = 1'b0;
    case (state_reg)
      ST_IDLE, ST_LOAD: ready_next = 1'b1;
      ST_SHIFT:         ready_next = (cnt_reg == LAST_BIT) && !last_flag_reg;
      default:          ready_next = 1'b0;
    endcase
  end

  assign in_ready = rst_n & ready_next;
  assign transfer = in_valid & in_ready;
  assign d        = d_reg;
  assign s        = s_reg;
  assign d_vld    = d_vld_reg;

`ifdef DEMUX_PARITY_EN
  logic par_acc_reg;
  logic par_vld_reg;
  assign par_vld = par_vld_reg;
`else
  assign par_vld = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      last_flag_reg <= 1'b0;
      d_reg         <= 1'b0;
      s_reg         <= 2'b00;
      d_vld_reg     <= 1'b0;
`ifdef DEMUX_PARITY_EN
      par_acc_reg   <= 1'b0;
      par_vld_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          d_reg     <= 1'b0;
          d_vld_reg <= 1'b0;
          // A header flagged last is an empty frame and is dropped silently.
          if (transfer && !in_last) begin
            s_reg     <= in_data[1:0];
            state_reg <= ST_LOAD;
`ifdef DEMUX_PARITY_EN
            par_acc_reg <= 1'b0;
`endif
          end
        end

        ST_LOAD: begin
          if (transfer) begin
            shift_reg     <= shift_out(in_data);
            d_reg         <= first_bit(in_data);
            d_vld_reg     <= 1'b1;
            cnt_reg       <= '0;
            last_flag_reg <= in_last;
            state_reg     <= ST_SHIFT;
`ifdef DEMUX_PARITY_EN
            par_acc_reg   <= par_acc_reg ^ first_bit(in_data);
`endif
          end
        end

        ST_SHIFT: begin
          if (cnt_reg != LAST_BIT) begin
            d_reg     <= first_bit(shift_reg);
            shift_reg <= shift_out(shift_reg);
            cnt_reg   <= cnt_reg + 1'b1;
`ifdef DEMUX_PARITY_EN
            par_acc_reg <= par_acc_reg ^ first_bit(shift_reg);
`endif
          end else if (transfer) begin
            // Zero-gap reload keeps d_vld high across word boundaries.
            shift_reg     <= shift_out(in_data);
            d_reg         <= first_bit(in_data);
            cnt_reg       <= '0;
            last_flag_reg <= in_last;
`ifdef DEMUX_PARITY_EN
            par_acc_reg   <= par_acc_reg ^ first_bit(in_data);
`endif
          end else if (!last_flag_reg) begin
            d_reg     <= 1'b0;
            d_vld_reg <= 1'b0;
            state_reg <= ST_LOAD;
          end else begin
`ifdef DEMUX_PARITY_EN
            d_reg       <= par_acc_reg;
            par_vld_reg <= 1'b1;
            state_reg   <= ST_PAR;
`else
            d_reg     <= 1'b0;
            d_vld_reg <= 1'b0;
            state_reg <= ST_IDLE;
`endif
          end
        end

`ifdef DEMUX_PARITY_EN
        ST_PAR: begin
          d_reg       <= 1'b0;
          d_vld_reg   <= 1'b0;
          par_vld_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
`endif

        default: begin
          d_reg     <= 1'b0;
          d_vld_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_frame_serializer.sv
// Scoreboard bench for demux_frame_serializer: directed frames, then random frames checked against a bit-stream model.
// Build with DEMUX_PARITY_EN defined to also expect the trailing parity bit.
module tb_demux_frame_serializer;

  localparam int DATA_W    = 8;
  localparam bit MSB_FIRST = 1'b1;
`ifdef DEMUX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              d;
  logic [1:0]        s;
  logic              d_vld;
  logic              par_vld;

  demux_frame_serializer #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .d        (d),
    .s        (s),
    .d_vld    (d_vld),
    .par_vld  (par_vld)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       d;
    logic [1:0] s;
    logic       par;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         runs[$];
  int         cur_run = 0;
  int         errors = 0;
  int         checks = 0;
  logic [1:0] model_s = 2'b00;
  logic       model_par = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a frame is just its payload bits in wire order, plus an even-parity bit when enabled.
  task automatic expect_header(input logic [DATA_W-1:0] data);
    model_s   = data[1:0];
    model_par = 1'b0;
  endtask

  task automatic expect_word(input logic [DATA_W-1:0] data, input logic last);
    exp_t e;
    for (int k = 0; k < DATA_W; k++) begin
      e.d   = MSB_FIRST ? data[DATA_W-1-k] : data[k];
      e.s   = model_s;
      e.par = 1'b0;
      model_par = model_par ^ e.d;
      exp_q.push_back(e);
    end
    if (last && PAR_EN != 0) begin
      e.d   = model_par;
      e.s   = model_s;
      e.par = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] data, input logic last, output int waits);
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) chk("handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("xfer data=%h last=%0d waits=%0d", data, last, waits);
  endtask

  task automatic send_hdr(input logic [DATA_W-1:0] data, input logic last);
    int w;
    if (!last) expect_header(data);
    send(data, last, w);
  endtask

  task automatic send_pay(input logic [DATA_W-1:0] data, input logic last, output int w);
    expect_word(data, last);
    send(data, last, w);
  endtask

  task automatic wait_runs(input int n, output int len);
    int t;
    t = 0;
    while (runs.size() < n && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (runs.size() < n) begin
      chk("run_timeout", runs.size(), n);
      len = -1;
    end else begin
      len = runs[n-1];
    end
  endtask

  // Monitor: every valid bit is popped and compared; idle cycles must be quiet.
  always @(negedge clk) begin
    if (rst_n) begin
      if (d_vld) begin
        cur_run++;
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_d", int'(d), int'(mon_e.d));
          chk("sb_s", int'(s), int'(mon_e.s));
          chk("sb_par_vld", int'(par_vld), int'(mon_e.par));
        end
      end else begin
        if (cur_run > 0) runs.push_back(cur_run);
        cur_run = 0;
        chk("idle_d", int'(d), 0);
        chk("idle_par_vld", int'(par_vld), 0);
      end
    end else begin
      cur_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int len;
    int n;
    int t;
    logic [DATA_W-1:0] hdr;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_s", int'(s), 0);
    chk("rst_d_vld", int'(d_vld), 0);
    chk("rst_par_vld", int'(par_vld), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", int'(in_ready), 1);

    // Single-word frame on channel 2
    runs.delete();
    send_hdr(8'h02, 1'b0);
    chk("t1_s_after_hdr", int'(s), 2);
    send_pay(8'hA5, 1'b1, w);
    chk("t1_first_bit_latency", int'(d_vld), 1);
    wait_runs(1, len);
    chk("t1_run_len", len, DATA_W + PAR_EN);
    chk("t1_d_vld_after", int'(d_vld), 0);
    chk("t1_in_ready_after", int'(in_ready), 1);

    // Back-to-back payload words
    runs.delete();
    send_hdr(8'h03, 1'b0);
    send_pay(8'hFF, 1'b0, w);
    send_pay(8'h00, 1'b1, w);
    chk("t2_ready_pulse_cycle", w, DATA_W - 1);
    wait_runs(1, len);
    chk("t2_run_len", len, 2 * DATA_W + PAR_EN);

    // Stalled payload: LOAD holds outputs quiet
    runs.delete();
    send_hdr(8'h01, 1'b0);
    send_pay(8'h81, 1'b0, w);
    wait_runs(1, len);
    chk("t3_run1_len", len, DATA_W);
    for (int i = 0; i < 3; i++) begin
      chk("t3_load_d_vld", int'(d_vld), 0);
      chk("t3_load_d", int'(d), 0);
      chk("t3_load_s", int'(s), 1);
      chk("t3_load_in_ready", int'(in_ready), 1);
      @(negedge clk);
      #1;
    end
    send_pay(8'h01, 1'b1, w);
    wait_runs(2, len);
    chk("t3_run2_len", len, DATA_W + PAR_EN);

    // Empty frame: nothing emitted, s holds
    runs.delete();
    send_hdr(8'h02, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    chk("t4_s_held", int'(s), 1);
    chk("t4_d_vld", int'(d_vld), 0);
    chk("t4_no_runs", runs.size() + cur_run, 0);

    // Reset during bit 4 of a payload word
    send_hdr(8'h01, 1'b0);
    send_pay(8'hC3, 1'b1, w);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_d", int'(d), 0);
    chk("t5_rst_s", int'(s), 0);
    chk("t5_rst_d_vld", int'(d_vld), 0);
    chk("t5_rst_par_vld", int'(par_vld), 0);
    chk("t5_rst_in_ready", int'(in_ready), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    runs.delete();
    send_hdr(8'h02, 1'b0);
    chk("t5_new_hdr_s", int'(s), 2);
    send_pay(8'h3C, 1'b1, w);
    wait_runs(1, len);
    chk("t5_run_len", len, DATA_W + PAR_EN);

    // Parity frame (parity bit expected only when enabled)
    runs.delete();
    send_hdr(8'h00, 1'b0);
    send_pay(8'h07, 1'b0, w);
    send_pay(8'h01, 1'b1, w);
    wait_runs(1, len);
    chk("t6_run_len", len, 2 * DATA_W + PAR_EN);

    // Random frames with random stalls
    for (int f = 0; f < 40; f++) begin
      hdr = DATA_W'($urandom);
      if ($urandom % 8 == 0) begin
        $display("frame %0d: empty hdr=%h", f, hdr);
        send_hdr(hdr, 1'b1);
      end else begin
        n = 1 + int'($urandom % 4);
        $display("frame %0d: hdr=%h words=%0d", f, hdr, n);
        send_hdr(hdr, 1'b0);
        for (int j = 0; j < n; j++) begin
          if ($urandom % 2 == 0) repeat ($urandom % 4) @(negedge clk);
          send_pay(DATA_W'($urandom), (j == n - 1), w);
        end
      end
    end

    t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
